// File: rtl/wave_rom_arbiter_if.sv
// wave_rom_arbiter_if: requester/ROM-side bus of the wave ROM read arbiter
interface wave_rom_arbiter_if #(
  parameter int CHANNELS = 8,
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 8
);
  logic                       dl_busy;
  logic [CHANNELS-1:0]        req;
  logic [CHANNELS*ADDR_W-1:0] req_addr;
  logic [CHANNELS-1:0]        ack;
  logic [DATA_W-1:0]          rd_data;
  logic [ADDR_W-1:0]          rom_addr;
  logic [DATA_W-1:0]          rom_q;
  logic                       busy;
  modport master (output dl_busy, req, req_addr, rom_q, input ack, rd_data, rom_addr, busy);
  modport slave  (input dl_busy, req, req_addr, rom_q, output ack, rd_data, rom_addr, busy);
endinterface

// File: rtl/wave_rom_arbiter.sv
// wave_rom_arbiter: round-robin G/R/A pipeline sharing one ROM read port between wave DMA channels
module wave_rom_arbiter #(
  parameter int CHANNELS = 8,
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 8
) (
  input logic clk_sys,
  input logic reset,
  wave_rom_arbiter_if.slave bus
);
  localparam int IW = $clog2(CHANNELS);
  logic [IW-1:0]       last_q, last_d, g_idx_q, g_idx_d, r_idx_q, r_idx_d;
  logic                g_vld_q, g_vld_d, r_vld_q, r_vld_d;
  logic [CHANNELS-1:0] inflight_q, inflight_d, ack_q, ack_d, elig;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  always_comb begin
    elig = bus.req & ~inflight_q & {CHANNELS{~bus.dl_busy}};
    g_vld_d = 1'b0;
    g_idx_d = last_q;
    // scan from farthest to nearest so the channel right after last_q wins
    for (int o = CHANNELS; o >= 1; o--) begin
      if (elig[(int'(last_q) + o) % CHANNELS]) begin
        g_vld_d = 1'b1;
        g_idx_d = IW'((int'(last_q) + o) % CHANNELS);
      end
    end
    last_d     = g_vld_d ? g_idx_d : last_q;
    rom_addr_d = g_vld_d ? bus.req_addr[g_idx_d*ADDR_W +: ADDR_W] : rom_addr_q;
    inflight_d = (inflight_q & ~ack_q) | (g_vld_d ? (CHANNELS'(1) << g_idx_d) : '0);
    r_vld_d    = g_vld_q;
    r_idx_d    = g_idx_q;
    ack_d      = r_vld_q ? (CHANNELS'(1) << r_idx_q) : '0;
    rd_data_d  = r_vld_q ? bus.rom_q : rd_data_q;
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      last_q     <= IW'(CHANNELS-1);
      g_vld_q    <= 1'b0;
      g_idx_q    <= '0;
      r_vld_q    <= 1'b0;
      r_idx_q    <= '0;
      inflight_q <= '0;
      ack_q      <= '0;
      rom_addr_q <= '0;
      rd_data_q  <= '0;
    end else begin
      last_q     <= last_d;
      g_vld_q    <= g_vld_d;
      g_idx_q    <= g_idx_d;
      r_vld_q    <= r_vld_d;
      r_idx_q    <= r_idx_d;
      inflight_q <= inflight_d;
      ack_q      <= ack_d;
      rom_addr_q <= rom_addr_d;
      rd_data_q  <= rd_data_d;
    end
  end
  assign bus.ack      = ack_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.busy     = |inflight_q;
endmodule

// File: tb/tb_wave_rom_arbiter.sv
// tb_wave_rom_arbiter: lockstep scoreboard bench for wave_rom_arbiter
module tb_wave_rom_arbiter;
  localparam int CH = 8;
  localparam int AW = 17;
  localparam int DW = 8;
  typedef struct {int ch; logic [DW-1:0] data; int due;} exp_t;
  logic clk_sys = 1'b0;
  logic reset;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  exp_t sb [$];
  int n_vec = 0, n_err = 0, cyc = 0;
  int m_last;
  logic [CH-1:0] m_inflight, m_ack, keep;
  logic [AW-1:0] m_addr;
  int start [CH];
  wave_rom_arbiter_if #(.CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW)) bus ();
  wave_rom_arbiter #(.CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) bus.rom_q <= mem[bus.rom_addr];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  task automatic set_req(input int c, input logic [AW-1:0] a);
    bus.req[c] = 1'b1;
    bus.req_addr[c*AW +: AW] = a;
  endtask
  task automatic cycle();
    logic [CH-1:0] elig, nxt;
    int g;
    exp_t e;
    if (reset) begin
      sb.delete();
      m_inflight = '0;
      m_ack = '0;
      m_last = CH-1;
      m_addr = '0;
    end else begin
      elig = bus.req & ~m_inflight & {CH{~bus.dl_busy}};
      g = -1;
      for (int o = 1; o <= CH; o++)
        if (g < 0 && elig[(m_last+o)%CH]) g = (m_last+o)%CH;
      nxt = m_inflight & ~m_ack;
      if (g >= 0) begin
        nxt[g] = 1'b1;
        m_last = g;
        m_addr = bus.req_addr[g*AW +: AW];
        sb.push_back('{g, mem[m_addr], cyc+3});
      end
      m_inflight = nxt;
    end
    @(posedge clk_sys);
    #1;
    cyc++;
    m_ack = '0;
    if (!reset && sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      m_ack[e.ch] = 1'b1;
      check("rd_data", 32'(bus.rd_data), 32'(e.data));
    end
    check("ack", 32'(bus.ack), 32'(m_ack));
    check("rom_addr", 32'(bus.rom_addr), 32'(m_addr));
    check("busy", 32'(bus.busy), 32'(|m_inflight));
    for (int c = 0; c < CH; c++)
      if (bus.ack[c] && start[c] >= 0) begin
        check("wait", 32'((cyc - start[c]) <= CH+6), 32'd1);
        start[c] = -1;
      end
    bus.req &= ~(m_ack & ~keep);
  endtask
  task automatic do_reset();
    bus.req = '0;
    bus.dl_busy = 1'b0;
    keep = '0;
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
  endtask
  initial begin
    logic [AW-1:0] b2b [3];
    b2b[0] = 17'h1FFFE;
    b2b[1] = 17'h1FFFF;
    b2b[2] = 17'h00000;
    for (int a = 0; a < (1<<AW); a++) mem[a] = DW'(a ^ (a >> 8) ^ ((a >> 13) * 3));
    for (int i = 0; i < CH; i++) begin
      mem[i] = DW'(8'h40 + i);
      start[i] = -1;
    end
    mem[17'h10] = 8'hA5;
    mem[17'h1FFFE] = 8'h3C;
    mem[17'h1FFFF] = 8'hC3;
    bus.req_addr = '0;
    do_reset();
    check("rd_rst", 32'(bus.rd_data), 32'd0);
    set_req(3, 17'h00010);
    cycle();
    check("single_addr", 32'(bus.rom_addr), 32'h10);
    repeat (2) cycle();
    check("single_ack", 32'(bus.ack), 32'h08);
    check("single_data", 32'(bus.rd_data), 32'hA5);
    repeat (3) cycle();
    do_reset();
    keep = '1;
    for (int i = 0; i < CH; i++) set_req(i, AW'(i));
    repeat (20) cycle();
    keep = '0;
    repeat (12) cycle();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_req(5, b2b[k]);
      for (int n = 0; n < 10 && !m_ack[5]; n++) cycle();
      check("b2b_ack", 32'(bus.ack[5]), 32'd1);
    end
    repeat (3) cycle();
    do_reset();
    for (int i = 0; i < 5; i++) set_req(i, AW'(17'h100 + i));
    repeat (2) cycle();
    bus.dl_busy = 1'b1;
    repeat (6) cycle();
    check("dl_idle", 32'(bus.busy), 32'd0);
    bus.dl_busy = 1'b0;
    repeat (14) cycle();
    do_reset();
    set_req(2, 17'h00222);
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rst_addr", 32'(bus.rom_addr), 32'd0);
    set_req(5, 17'h00555);
    cycle();
    check("rst_regrant", 32'(bus.rom_addr), 32'h222);
    repeat (10) cycle();
    do_reset();
    for (int t = 0; t < 10000; t++) begin
      for (int c = 0; c < CH; c++)
        if (!bus.req[c] && $urandom_range(0, 2) == 0) begin
          set_req(c, AW'($urandom_range(0, (1<<AW)-1)));
          start[c] = cyc;
        end
      cycle();
    end
    bus.req = '0;
    repeat (8) cycle();
    check("drain_busy", 32'(bus.busy), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wave_rom_arbiter.md
# wave_rom_arbiter

Round-robin read arbiter sharing the single read port of the wave-sample ROM (the download dual-port RAM, port b) between up to eight wave-sound DMA channels. It sits between the `wave_sound` channel engines and the ROM. It issues at most one ROM read per clock and returns each byte to its requester with a one-cycle acknowledge. While a ROM download is in progress, no new reads are granted.

## Interface
Parameters:
- CHANNELS, 8, number of requesters (2..8)
- ADDR_W, 17, ROM byte-address width
- DATA_W, 8, ROM data width

Ports:
- clk_sys  in  1  single system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- dl_busy  in  1  ROM download in progress; blocks new grants
- req  in  CHANNELS  per-channel read request, level, held until acknowledged
- req_addr  in  CHANNELS*ADDR_W  flattened addresses; channel i uses bits [i*ADDR_W +: ADDR_W]; held stable while req[i] is high
- ack  out  CHANNELS  one-cycle pulse; rd_data is valid for channel i
- rd_data  out  DATA_W  returned byte, broadcast to all channels, valid only with ack
- rom_addr  out  ADDR_W  registered address to ROM read port
- rom_q  in  DATA_W  ROM read data, one clock after rom_addr is sampled
- busy  out  1  any access in flight (OR of inflight bits)

## Operation
- Pipeline stages per access:
  - G (grant register)
  - R (ROM read)
  - A (ack/data register)
- Each stage holds a valid bit and a channel index.
- Eligibility: req[i] & ~inflight[i] & ~dl_busy.
- inflight[i] sets at the grant edge and clears at the edge after ack[i]. Requesters may therefore deassert req with a registered `if (ack) req <= 0`.
- Arbitration: rotating priority. The search starts at last_grant+1 mod CHANNELS. The first eligible channel is granted and last_grant is updated. last_grant resets to CHANNELS-1, so channel 0 has first priority after reset.
- Grant edge: rom_addr <= req_addr of the granted channel; G valid <= 1, G index <= granted channel. With no eligible channel, G valid <= 0 and rom_addr holds its value.
- R stage: index and valid copy from G. The ROM samples rom_addr on this edge.
- A stage: rd_data <= rom_q; ack[idx] <= 1 for one cycle when R is valid.
- Throughput: one grant per cycle across channels. A single channel can be re-granted no sooner than 4 cycles after its previous grant.
- Fairness: with all channels requesting continuously, every channel is granted exactly once per CHANNELS consecutive grants.
- dl_busy:
  - Sampled at the grant edge only. While it is high, no grants are issued.
  - Accesses already in G/R complete and ack normally, even if their data is now stale.
  - last_grant is frozen while dl_busy is high.
- Address: passed through unmodified, no wrap or arithmetic. Out-of-range channel addresses are the requester's problem.

## Timing
- Reset values:
  - ack = 0, rd_data = 0, rom_addr = 0, busy = 0
  - all stage valids = 0, all inflight = 0, last_grant = CHANNELS-1
- Latency: req[i] high and eligible at edge k:
  - rom_addr valid after edge k
  - rom_q valid after edge k+1
  - ack[i] = 1 and rd_data valid after edge k+2, for exactly one cycle
  - inflight[i] clears at edge k+3; earliest re-grant is edge k+4
- At most one ack bit is high in any cycle.
- Simultaneous events:
  - A new grant at the same edge as another channel's ack is allowed.
  - A requester whose ack is high is not eligible in that cycle.
- Reset mid-operation:
  - The pipeline is flushed and no ack is emitted for accesses in flight.
  - Requesters see inflight cleared and re-request.
- req dropped before ack (protocol violation): the access still completes and acks. No error is flagged.

## Test plan
- Single request: req[3]=1, addr=0x00010, ROM[0x10]=0xA5 → rom_addr=0x00010 after edge k, ack[3] pulse with rd_data=0xA5 after edge k+2. No other ack.
- All eight requesting from reset, addr_i = i, ROM[i] = 0x40+i:
  - grants in order 0,1,…,7 on consecutive edges
  - acks in the same order, 2 cycles later, data 0x40..0x47
  - ninth grant goes back to channel 0 no sooner than 4 cycles after its first grant
- Back-to-back on one channel: req[5] held high, address stepping 0x1FFFE, 0x1FFFF, 0x00000 → grants exactly 4 cycles apart, data correct at top-of-range and zero addresses.
- Download lockout:
  - dl_busy rises with 2 accesses in flight and 3 channels requesting → the 2 in-flight accesses ack, no new grants while dl_busy is high
  - dl_busy falls → grants resume from last_grant+1
- Reset mid-flight: reset asserted one cycle after a grant to channel 2 → no ack at any later cycle, busy=0, rom_addr=0 after reset. First grant after reset goes to the lowest requesting channel.
- Fairness stress: random req patterns for 10k cycles:
  - no channel waits more than CHANNELS+3 cycles once eligible
  - every ack matches a prior grant
  - rd_data always equals the ROM model at the granted address
